fpu_shared_arbiter: RTL and testbench

//  Shares one fpu_private instance among NUM_REQ requesters (cores/LSU ports). Round-robin arbitration,
//  one operation in flight at a time, result/flags routed back to the issuing requester. Sits between

---
 rtl/fpu_shared_arbiter_pkg.sv | 19 +
 rtl/fpu_shared_arbiter_rr_pick.sv | 26 ++
 rtl/fpu_shared_arbiter.sv | 105 ++++++++++
 tb/tb_fpu_shared_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_shared_arbiter_pkg.sv
// fpu_shared_arbiter_pkg: FPU field widths, commands and shared-arbiter types
package fpu_shared_arbiter_pkg;
  localparam int C_OP = 32;
  localparam int C_RM = 3;
  localparam int C_CMD = 4;
  localparam int C_PC = 5;
  localparam int C_FFLAG = 5;
  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD = 4'h3;
  localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD = 4'h6;
  localparam logic [C_OP-1:0] C_FPU_CANON_NAN = 32'h7FC0_0000;
  localparam logic [C_FFLAG-1:0] C_ARB_TIMEOUT_FLAGS = 5'b10000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  function automatic logic is_divsqrt(input logic [C_CMD-1:0] cmd);
    return cmd == C_FPU_DIV_CMD || cmd == C_FPU_SQRT_CMD;
  endfunction
endpackage

// File: rtl/fpu_shared_arbiter_rr_pick.sv
// fpu_rr_pick: combinational round-robin pick of the first request at or after ptr
module fpu_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] k;
  always_comb begin
    k = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!any && req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/fpu_shared_arbiter.sv
// fpu_shared_arbiter: round-robin sharing of one FPU among NUM_REQ requesters, one op in flight
module fpu_shared_arbiter
  import fpu_shared_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [C_OP-1:0]      op_a_i [NUM_REQ],
  input  logic [C_OP-1:0]      op_b_i [NUM_REQ],
  input  logic [C_OP-1:0]      op_c_i [NUM_REQ],
  input  logic [C_RM-1:0]      rm_i [NUM_REQ],
  input  logic [C_CMD-1:0]     cmd_i [NUM_REQ],
  input  logic [C_PC-1:0]      prec_i [NUM_REQ],
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   resp_valid_o,
  output logic [C_OP-1:0]      resp_result_o,
  output logic [C_FFLAG-1:0]   resp_flags_o,
  output logic                 fpu_en_o,
  output logic [C_OP-1:0]      fpu_op_a_o,
  output logic [C_OP-1:0]      fpu_op_b_o,
  output logic [C_OP-1:0]      fpu_op_c_o,
  output logic [C_RM-1:0]      fpu_rm_o,
  output logic [C_CMD-1:0]     fpu_cmd_o,
  output logic [C_PC-1:0]      fpu_prec_o,
  input  logic [C_OP-1:0]      fpu_result_i,
  input  logic [C_FFLAG-1:0]   fpu_flags_i,
  input  logic                 fpu_valid_i,
  input  logic                 fpu_divsqrt_busy_i,
  output logic                 timeout_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  arb_state_t state, state_n;
  logic [IW-1:0] ptr, owner, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic pick_any, accept, wd_fire;
  logic [WW-1:0] wd;
  fpu_rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req_i),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  // a busy div/sqrt head blocks everyone behind it so the rotation order never changes
  assign accept = !rst_i && state == IDLE && pick_any && !(is_divsqrt(cmd_i[pick_idx]) && fpu_divsqrt_busy_i);
  assign wd_fire = wd == WW'(TIMEOUT_CYC - 1);
  always_comb begin
    state_n = state;
    gnt_o = accept ? pick_gnt : '0;
    fpu_en_o = state == ISSUE;
    resp_valid_o = state == RESP ? NUM_REQ'(1) << owner : '0;
    case (state)
      IDLE:    state_n = accept ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = fpu_valid_i || wd_fire ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      wd <= '0;
      timeout_o <= 1'b0;
      resp_result_o <= '0;
      resp_flags_o <= '0;
      fpu_op_a_o <= '0;
      fpu_op_b_o <= '0;
      fpu_op_c_o <= '0;
      fpu_rm_o <= '0;
      fpu_cmd_o <= '0;
      fpu_prec_o <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        owner <= pick_idx;
        fpu_op_a_o <= op_a_i[pick_idx];
        fpu_op_b_o <= op_b_i[pick_idx];
        fpu_op_c_o <= op_c_i[pick_idx];
        fpu_rm_o <= rm_i[pick_idx];
        fpu_cmd_o <= cmd_i[pick_idx];
        fpu_prec_o <= prec_i[pick_idx];
      end
      if (state == ISSUE)
        wd <= '0;
      else if (state == WAIT && wd != '1)
        wd <= wd + 1'b1;
      if (state == WAIT && fpu_valid_i) begin
        resp_result_o <= fpu_result_i;
        resp_flags_o <= fpu_flags_i;
      end else if (state == WAIT && wd_fire) begin
        resp_result_o <= C_FPU_CANON_NAN;
        resp_flags_o <= C_ARB_TIMEOUT_FLAGS;
        timeout_o <= 1'b1;
      end
      if (state == RESP)
        ptr <= owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// tb_fpu_shared_arbiter: randomized scenarios against a round-robin reference and a stub FPU
module tb_fpu_shared_arbiter;
  import fpu_shared_arbiter_pkg::*;
  localparam int N = 4;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1, busy = 1'b0;
  logic [N-1:0] req = '0;
  logic [C_OP-1:0] op_a [N], op_b [N], op_c [N];
  logic [C_RM-1:0] rm [N];
  logic [C_CMD-1:0] cmd [N];
  logic [C_PC-1:0] prec [N];
  logic [N-1:0] gnt, resp_valid;
  logic [C_OP-1:0] resp_result, fpu_a, fpu_b, fpu_c;
  logic [C_FFLAG-1:0] resp_flags;
  logic fpu_en, timeout;
  logic [C_RM-1:0] fpu_rm;
  logic [C_CMD-1:0] fpu_cmd;
  logic [C_PC-1:0] fpu_prec;
  logic [C_OP-1:0] fpu_result = '0;
  logic [C_FFLAG-1:0] fpu_flags = '0;
  logic fpu_valid = 1'b0;
  int checks = 0, failures = 0, rr = 0, fpu_lat = 3, fpu_cnt = 0;
  bit fpu_drop = 1'b0;
  always #5 clk = ~clk;
  fpu_shared_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .rm_i(rm), .cmd_i(cmd), .prec_i(prec),
    .gnt_o(gnt), .resp_valid_o(resp_valid), .resp_result_o(resp_result), .resp_flags_o(resp_flags),
    .fpu_en_o(fpu_en), .fpu_op_a_o(fpu_a), .fpu_op_b_o(fpu_b), .fpu_op_c_o(fpu_c),
    .fpu_rm_o(fpu_rm), .fpu_cmd_o(fpu_cmd), .fpu_prec_o(fpu_prec),
    .fpu_result_i(fpu_result), .fpu_flags_i(fpu_flags), .fpu_valid_i(fpu_valid),
    .fpu_divsqrt_busy_i(busy), .timeout_o(timeout)
  );
  // stub FPU arithmetic: a fixed scramble of every field, with 1.0+2.0 answered exactly
  function automatic logic [C_OP-1:0] ref_res(input logic [C_OP-1:0] a, b, c, input logic [C_RM-1:0] r,
                                               input logic [C_CMD-1:0] m, input logic [C_PC-1:0] p);
    if (m == C_FPU_ADD_CMD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ {c[28:0], 3'b0} ^ {20'b0, p, r, m};
  endfunction
  function automatic logic [C_FFLAG-1:0] ref_flg(input logic [C_OP-1:0] a, b, c, input logic [C_RM-1:0] r,
                                                  input logic [C_CMD-1:0] m, input logic [C_PC-1:0] p);
    if (m == C_FPU_ADD_CMD && a == 32'h3F80_0000 && b == 32'h4000_0000) return '0;
    return a[4:0] ^ b[9:5] ^ c[14:10] ^ p ^ {2'b0, r};
  endfunction
  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // stub FPU: result appears fpu_lat cycles after the enable pulse, or never when dropping
  always @(posedge clk) begin
    int c;
    c = fpu_en ? (fpu_drop ? 0 : fpu_lat) : (fpu_cnt > 0 ? fpu_cnt - 1 : 0);
    fpu_cnt <= c;
    fpu_valid <= c == 1;
    if (fpu_en) begin
      fpu_result <= ref_res(fpu_a, fpu_b, fpu_c, fpu_rm, fpu_cmd, fpu_prec);
      fpu_flags <= ref_flg(fpu_a, fpu_b, fpu_c, fpu_rm, fpu_cmd, fpu_prec);
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; req = '0; busy = 1'b0; fpu_drop = 1'b0;
    tick(); tick();
    rst = 1'b0; rr = 0;
  endtask
  task automatic load(input int i, input logic [C_CMD-1:0] c);
    op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = $urandom;
    rm[i] = C_RM'($urandom); prec[i] = C_PC'($urandom); cmd[i] = c;
  endtask
  task automatic await_gnt(output logic [N-1:0] g, output int cyc);
    g = '0; cyc = 0;
    while (cyc < 50) begin
      #1;
      if (gnt !== '0) begin g = gnt; break; end
      tick(); cyc++;
    end
  endtask
  task automatic await_resp(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (resp_valid === '0 && cyc < 200);
  endtask
  task automatic test_reset();
    rst = 1'b1; req = '1;
    tick(); tick(); #1;
    checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
    checks++; if (resp_valid !== '0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if ({resp_result, resp_flags} !== '0) begin failures++; $display("FAIL reset_resp_data got=%h/%b exp=0", resp_result, resp_flags); end
    checks++; if ({fpu_en, timeout} !== 2'b00) begin failures++; $display("FAIL reset_en_timeout got=%b%b exp=00", fpu_en, timeout); end
    checks++; if ({fpu_a, fpu_b, fpu_c, fpu_rm, fpu_cmd, fpu_prec} !== '0) begin failures++; $display("FAIL reset_fpu_regs got=%h exp=0", fpu_a); end
    rst = 1'b0; req = '0; rr = 0;
  endtask
  task automatic test_single_add();
    logic [N-1:0] g;
    int cyc;
    do_reset(); fpu_lat = 2;
    op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000; op_c[0] = '0; rm[0] = '0; prec[0] = '0;
    cmd[0] = C_FPU_ADD_CMD; req = 4'b0001;
    await_gnt(g, cyc);
    checks++; if (g !== 4'b0001 || cyc != 0) begin failures++; $display("FAIL add_gnt got=%b after %0d exp=0001 after 0", g, cyc); end
    tick(); req = '0;
    checks++; if (fpu_en !== 1'b1 || fpu_a !== 32'h3F80_0000 || fpu_b !== 32'h4000_0000) begin failures++; $display("FAIL add_issue got en=%b a=%h b=%h exp en=1 a=3f800000 b=40000000", fpu_en, fpu_a, fpu_b); end
    await_resp(cyc);
    checks++; if (cyc != fpu_lat + 1) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", cyc, fpu_lat + 1); end
    checks++; if (resp_valid !== 4'b0001 || resp_result !== 32'h4040_0000 || resp_flags !== '0) begin failures++; $display("FAIL add_resp got=%b %h %b exp=0001 40400000 00000", resp_valid, resp_result, resp_flags); end
    tick();
    checks++; if (resp_valid !== '0) begin failures++; $display("FAIL add_resp_pulse got=%b exp=0", resp_valid); end
    rr = 1;
  endtask
  task automatic test_rr();
    logic [N-1:0] g;
    logic [C_OP-1:0] er;
    logic [C_FFLAG-1:0] ef;
    int cyc, w;
    do_reset(); fpu_lat = 1 + int'($urandom_range(0, 3));
    for (int i = 0; i < N; i++) load(i, C_FPU_MUL_CMD);
    req = '1;
    for (int n = 0; n < 5; n++) begin
      w = winner(req, rr);
      er = ref_res(op_a[w], op_b[w], op_c[w], rm[w], cmd[w], prec[w]);
      ef = ref_flg(op_a[w], op_b[w], op_c[w], rm[w], cmd[w], prec[w]);
      await_gnt(g, cyc);
      checks++; if (g !== N'(1) << w) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", n, g, N'(1) << w); end
      tick(); load(w, C_FPU_MUL_CMD);
      await_resp(cyc);
      checks++; if (resp_valid !== N'(1) << w || resp_result !== er || resp_flags !== ef) begin failures++; $display("FAIL rr_resp%0d got=%b %h %b exp=%b %h %b", n, resp_valid, resp_result, resp_flags, N'(1) << w, er, ef); end
      rr = (w + 1) % N;
      tick();
    end
    req = '0;
  endtask
  task automatic test_divsqrt_busy();
    logic [N-1:0] g, seen;
    int cyc;
    do_reset(); fpu_lat = 3;
    load(1, C_FPU_DIV_CMD); req = 4'b0010;
    await_gnt(g, cyc);
    checks++; if (g !== 4'b0010) begin failures++; $display("FAIL div_gnt got=%b exp=0010", g); end
    tick(); req = '0; busy = 1'b1;
    await_resp(cyc);
    checks++; if (resp_valid !== 4'b0010 || resp_result !== ref_res(op_a[1], op_b[1], op_c[1], rm[1], cmd[1], prec[1])) begin failures++; $display("FAIL div_resp got=%b %h", resp_valid, resp_result); end
    rr = 2; tick();
    load(2, C_FPU_SQRT_CMD); load(3, C_FPU_ADD_CMD); req = 4'b1100; seen = '0;
    for (int k = 0; k < 6; k++) begin #1; seen |= gnt | {N{fpu_en}}; tick(); end
    checks++; if (seen !== '0) begin failures++; $display("FAIL busy_hold got=%b exp=0", seen); end
    busy = 1'b0;
    await_gnt(g, cyc);
    checks++; if (g !== N'(1) << winner(req, rr)) begin failures++; $display("FAIL sqrt_gnt got=%b exp=%b", g, N'(1) << winner(req, rr)); end
    tick(); req[2] = 1'b0;
    await_resp(cyc);
    checks++; if (resp_valid !== 4'b0100 || resp_result !== ref_res(op_a[2], op_b[2], op_c[2], rm[2], cmd[2], prec[2])) begin failures++; $display("FAIL sqrt_resp got=%b %h", resp_valid, resp_result); end
    rr = 3; tick();
    await_gnt(g, cyc);
    checks++; if (g !== 4'b1000) begin failures++; $display("FAIL add3_gnt got=%b exp=1000", g); end
    tick(); req = '0;
    await_resp(cyc);
    checks++; if (resp_valid !== 4'b1000 || resp_flags !== ref_flg(op_a[3], op_b[3], op_c[3], rm[3], cmd[3], prec[3])) begin failures++; $display("FAIL add3_resp got=%b %b", resp_valid, resp_flags); end
    rr = 0; tick();
  endtask
  task automatic test_timeout_edge();
    logic [N-1:0] g;
    int cyc, i;
    do_reset(); fpu_lat = TO;
    i = int'($urandom_range(0, N - 1)); load(i, C_FPU_SUB_CMD); req = N'(1) << i;
    await_gnt(g, cyc);
    tick(); req = '0;
    await_resp(cyc);
    checks++; if (cyc != TO + 1 || resp_valid !== N'(1) << i) begin failures++; $display("FAIL edge_resp got=%b after %0d exp=%b after %0d", resp_valid, cyc, N'(1) << i, TO + 1); end
    checks++; if (resp_result !== ref_res(op_a[i], op_b[i], op_c[i], rm[i], cmd[i], prec[i]) || timeout !== 1'b0) begin failures++; $display("FAIL edge_valid_wins got=%h to=%b", resp_result, timeout); end
    rr = (i + 1) % N; tick();
  endtask
  task automatic test_timeout();
    logic [N-1:0] g;
    int cyc, i;
    fpu_drop = 1'b1;
    i = int'($urandom_range(0, N - 1)); load(i, C_FPU_MUL_CMD); req = N'(1) << i;
    await_gnt(g, cyc);
    checks++; if (g !== N'(1) << winner(N'(1) << i, rr)) begin failures++; $display("FAIL to_gnt got=%b", g); end
    tick(); req = '0;
    await_resp(cyc);
    checks++; if (cyc != TO + 1 || resp_valid !== N'(1) << i) begin failures++; $display("FAIL to_resp got=%b after %0d exp=%b after %0d", resp_valid, cyc, N'(1) << i, TO + 1); end
    checks++; if (resp_result !== 32'h7FC0_0000 || resp_flags !== 5'b10000 || timeout !== 1'b1) begin failures++; $display("FAIL to_data got=%h %b to=%b exp=7fc00000 10000 1", resp_result, resp_flags, timeout); end
    rr = (i + 1) % N; fpu_drop = 1'b0; tick();
    i = int'($urandom_range(0, N - 1)); load(i, C_FPU_ADD_CMD); req = N'(1) << i;
    await_gnt(g, cyc);
    tick(); req = '0;
    await_resp(cyc);
    checks++; if (resp_valid !== N'(1) << i || resp_result !== ref_res(op_a[i], op_b[i], op_c[i], rm[i], cmd[i], prec[i]) || timeout !== 1'b1) begin failures++; $display("FAIL after_to got=%b %h to=%b", resp_valid, resp_result, timeout); end
    rr = (i + 1) % N; tick();
  endtask
  task automatic test_reset_mid();
    logic [N-1:0] g, seen;
    logic stale;
    int cyc, i;
    fpu_lat = 10;
    i = int'($urandom_range(0, N - 1)); load(i, C_FPU_MUL_CMD); req = N'(1) << i;
    await_gnt(g, cyc);
    tick(); req = '0; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; rr = 0;
    seen = '0; stale = 1'b0;
    for (int k = 0; k < 14; k++) begin #1; seen |= resp_valid; stale |= fpu_valid; tick(); end
    checks++; if (seen !== '0 || stale !== 1'b1) begin failures++; $display("FAIL mid_reset_resp got=%b stale=%b exp=0 stale=1", seen, stale); end
    checks++; if ({resp_result, resp_flags, fpu_en, timeout} !== '0 || {fpu_a, fpu_b, fpu_c, fpu_cmd} !== '0) begin failures++; $display("FAIL mid_reset_state got=%h %b en=%b to=%b a=%h", resp_result, resp_flags, fpu_en, timeout, fpu_a); end
    fpu_lat = 2; load(3, C_FPU_SUB_CMD); load(1, C_FPU_SUB_CMD); req = 4'b1010;
    await_gnt(g, cyc);
    checks++; if (g !== N'(1) << winner(req, rr)) begin failures++; $display("FAIL mid_recover got=%b exp=%b", g, N'(1) << winner(req, rr)); end
    tick(); req = '0;
    await_resp(cyc);
    rr = 2; tick();
  endtask
  task automatic test_random();
    logic [N-1:0] g, r;
    logic [C_CMD-1:0] cs [3];
    int cyc, w;
    cs[0] = C_FPU_ADD_CMD; cs[1] = C_FPU_SUB_CMD; cs[2] = C_FPU_MUL_CMD;
    for (int n = 0; n < 12; n++) begin
      busy = 1'($urandom); fpu_lat = 1 + int'($urandom_range(0, 4));
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (r[i]) load(i, cs[$urandom_range(0, 2)]);
      req = r; w = winner(r, rr);
      await_gnt(g, cyc);
      checks++; if (g !== N'(1) << w || cyc != 0) begin failures++; $display("FAIL rand_gnt%0d got=%b after %0d exp=%b", n, g, cyc, N'(1) << w); end
      tick(); req = '0;
      await_resp(cyc);
      checks++; if (resp_valid !== N'(1) << w || cyc != fpu_lat + 1 || resp_result !== ref_res(op_a[w], op_b[w], op_c[w], rm[w], cmd[w], prec[w]) || resp_flags !== ref_flg(op_a[w], op_b[w], op_c[w], rm[w], cmd[w], prec[w])) begin failures++; $display("FAIL rand_resp%0d got=%b %h %b after %0d", n, resp_valid, resp_result, resp_flags, cyc); end
      rr = (w + 1) % N; tick();
    end
    busy = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) load(i, C_FPU_ADD_CMD);
    test_reset();
    test_single_add();
    test_rr();
    test_divsqrt_busy();
    test_timeout_edge();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
